// File: rtl/multiplier_timing_monitor_pkg.sv
// Shared definitions for the multiplier timing monitor: FSM encoding and default trial timeout.
package multiplier_timing_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BOTH  = 2'd1,
        WAIT_OTHER = 2'd2,
        REPORT     = 2'd3
    } monitorState;

    localparam int DEFAULT_TIMEOUT = 200;

endpackage

// File: rtl/multiplier_timing_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/multiplier_timing_monitor.sv
// Measures completion skew between two multiplier copies sharing one start pulse and
// keeps saturating trial/leak statistics plus a sticky record of the first leaking trial.
module multiplier_timing_monitor
    import multiplier_timing_monitor_pkg::*;
#(
    parameter int SKEW_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              doneOne,
    input  logic              doneTwo,
    output logic              busy,
    output logic              trialValid,
    output logic              trialLeak,
    output logic              trialTimeout,
    output logic [SKEW_W-1:0] trialSkew,
    output logic              leakSeen,
    output logic [CNT_W-1:0]  trialCount,
    output logic [CNT_W-1:0]  leakCount,
    output logic [CNT_W-1:0]  firstLeakTrial,
    output logic [SKEW_W-1:0] firstLeakSkew
);

    monitorState state, stateNext;
    logic prevOne, prevTwo, riseOne, riseTwo, firstIsOne, otherRise;
    logic reportEnter, leakNext, timeoutNext, timeoutHit;
    logic [SKEW_W-1:0] skewCnt, skewNow, skewNext;
    logic [15:0] elapsed;
    logic [CNT_W-1:0] trialCountNext;

    assign riseOne = doneOne & ~prevOne;
    assign riseTwo = doneTwo & ~prevTwo;
    assign busy = (state == WAIT_BOTH) || (state == WAIT_OTHER);
    assign trialValid = (state == REPORT);
    assign otherRise = firstIsOne ? riseTwo : riseOne;

    // elapsed is cleared on the acceptance edge, so it trails the cycle count by one
    assign timeoutHit = (elapsed == 16'(TIMEOUT - 1));

    // skewCnt trails the true skew by one; skewNow is the skew as of this cycle
    assign skewNow = (&skewCnt) ? skewCnt : skewCnt + SKEW_W'(1);
    assign trialCountNext = (&trialCount) ? trialCount : trialCount + CNT_W'(1);

    sat_counter #(.W(16)) uElapsed (
        .clk(clk), .rst(rst), .clr(state == IDLE), .inc(busy), .count(elapsed)
    );

    sat_counter #(.W(SKEW_W)) uSkew (
        .clk(clk), .rst(rst), .clr(state != WAIT_OTHER), .inc(state == WAIT_OTHER),
        .count(skewCnt)
    );

    sat_counter #(.W(CNT_W)) uTrials (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(reportEnter), .count(trialCount)
    );

    sat_counter #(.W(CNT_W)) uLeaks (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(reportEnter & leakNext), .count(leakCount)
    );

    always_comb begin
        stateNext   = state;
        reportEnter = 1'b0;
        leakNext    = 1'b0;
        timeoutNext = 1'b0;
        skewNext    = '0;
        case (state)
            IDLE: begin
                if (start) stateNext = WAIT_BOTH;
            end
            WAIT_BOTH: begin
                if (riseOne && riseTwo) begin
                    stateNext   = REPORT;
                    reportEnter = 1'b1;
                end else if (timeoutHit) begin
                    stateNext   = REPORT;
                    reportEnter = 1'b1;
                    leakNext    = 1'b1;
                    timeoutNext = 1'b1;
                end else if (riseOne || riseTwo) begin
                    stateNext = WAIT_OTHER;
                end
            end
            WAIT_OTHER: begin
                // completion beats a timeout landing in the same cycle
                if (otherRise || timeoutHit) begin
                    stateNext   = REPORT;
                    reportEnter = 1'b1;
                    leakNext    = 1'b1;
                    timeoutNext = !otherRise;
                    skewNext    = skewNow;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            prevOne        <= 1'b0;
            prevTwo        <= 1'b0;
            firstIsOne     <= 1'b0;
            trialLeak      <= 1'b0;
            trialTimeout   <= 1'b0;
            trialSkew      <= '0;
            leakSeen       <= 1'b0;
            firstLeakTrial <= '0;
            firstLeakSkew  <= '0;
        end else begin
            state   <= stateNext;
            prevOne <= doneOne;
            prevTwo <= doneTwo;
            if (state == WAIT_BOTH && (riseOne != riseTwo)) firstIsOne <= riseOne;
            if (reportEnter) begin
                trialLeak    <= leakNext;
                trialTimeout <= timeoutNext;
                trialSkew    <= skewNext;
                if (leakNext && !leakSeen) begin
                    leakSeen       <= 1'b1;
                    firstLeakTrial <= trialCountNext;
                    firstLeakSkew  <= skewNext;
                end
            end
        end
    end

endmodule
